// File: rtl/ctrl_seq_pkg.sv
// Shared types and field layout for the ctrl_seq instruction sequencer.
package ctrl_seq_pkg;

   typedef enum logic [1:0] {
      MEM_NOP   = 2'd0,
      MEM_READ  = 2'd1,
      MEM_WRITE = 2'd2
   } mem_ctrl_op_e;

   typedef enum logic [2:0] {
      AR_NOP = 3'd0,
      AR_INC = 3'd1
   } addr_register_op_e;

   typedef enum logic {
      ADDR_PC  = 1'b0,
      ADDR_MAR = 1'b1
   } addr_sel_e;

   typedef enum logic {
      REG_NOP   = 1'b0,
      REG_WRITE = 1'b1
   } registers_op_e;

   typedef enum logic [1:0] {
      MUX_ALU = 2'd0,
      MUX_MEM = 2'd1
   } mux_sel_e;

   typedef enum logic [1:0] {
      OP_NOP = 2'd0,
      OP_ALU = 2'd1,
      OP_LDX = 2'd2,
      OP_JMP = 2'd3
   } opcode_e;

   typedef enum logic [3:0] {
      ST_FETCH     = 4'd0,
      ST_DECODE    = 4'd1,
      ST_ALU_OP    = 4'd2,
      ST_LDX_READ  = 4'd3,
      ST_LDX_WRITE = 4'd4,
      ST_JMP_PARAM = 4'd5,
      ST_INC_PC    = 4'd6,
      ST_HALT      = 4'd7,
      ST_FAULT     = 4'd8
   } ctrl_seq_state_e;

   // Field positions below the MSB of an instruction byte (bit index = W-1-offset)
   localparam int unsigned OPCODE_W     = 2;
   localparam int unsigned MOD_BIT_OFS  = 2;
   localparam int unsigned JMP_ZM_OFS   = 3;
   localparam int unsigned JMP_REG_OFS  = 4;
   localparam int unsigned AR_OP_W      = 3;
   localparam int unsigned ALU_THR      = 0;

   function automatic logic is_wait_state(ctrl_seq_state_e s);
      return (s == ST_DECODE) || (s == ST_ALU_OP) || (s == ST_LDX_READ) ||
             (s == ST_LDX_WRITE) || (s == ST_JMP_PARAM);
   endfunction

endpackage

// File: rtl/ctrl_seq_timeout.sv
// Memory-handshake wait counter; expired_c flags the last permitted wait cycle.
module ctrl_seq_timeout #(
   parameter int unsigned LIMIT = 15
) (
   input  logic clock,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expired_c
);
   localparam int unsigned CNT_W = (LIMIT < 2) ? 1 : $clog2(LIMIT);
   localparam logic [CNT_W-1:0] LAST = CNT_W'((LIMIT == 0) ? 0 : LIMIT - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clear)
         cnt_d = '0;
      else if (enable && (cnt_q != LAST))
         cnt_d = cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

   // A LIMIT of zero disables the timeout entirely
   assign expired_c = (LIMIT != 0) && enable && (cnt_q == LAST);

endmodule

// File: rtl/ctrl_seq.sv
// Instruction sequencer for the simple-viii core with registered control outputs.
// Optional single-step gating of ST_FETCH is enabled by defining CTRL_SINGLE_STEP_EN.
module ctrl_seq
   import ctrl_seq_pkg::*;
#(
   parameter int unsigned DATA_BUS_WIDTH = 8,
   parameter int unsigned REG_SEL_WIDTH  = 2,
   parameter int unsigned ALU_OP_WIDTH   = 4,
   parameter int unsigned MEM_TIMEOUT    = 15
) (
   input  logic                      clock,
   input  logic                      reset,
`ifdef CTRL_SINGLE_STEP_EN
   input  logic                      step,
`endif
   input  logic [DATA_BUS_WIDTH-1:0] bus_data_in,
   input  logic                      mem_op_done,
   input  logic                      flag_carry,
   input  logic                      flag_zero,
   output logic [1:0]                mem_ctrl_op,
   output logic [2:0]                addr_reg_op,
   output logic                      addr_sel,
   output logic [ALU_OP_WIDTH-1:0]   alu_op,
   output logic                      reg_op,
   output logic [REG_SEL_WIDTH-1:0]  reg_sel_in,
   output logic [REG_SEL_WIDTH-1:0]  reg_sel_1,
   output logic [REG_SEL_WIDTH-1:0]  reg_sel_2,
   output logic [1:0]                mux_sel,
   output logic                      halted,
   output logic                      fault
);
   localparam int unsigned W            = DATA_BUS_WIDTH;
   localparam int unsigned OPC_LSB      = W - OPCODE_W;
   localparam int unsigned MOD_BIT      = W - 1 - MOD_BIT_OFS;
   localparam int unsigned ALU_RS1_HI   = MOD_BIT - ALU_OP_WIDTH;
   localparam int unsigned LDX_REG_HI   = MOD_BIT - 1;
   localparam int unsigned JMP_ZM_BIT   = W - 1 - JMP_ZM_OFS;
   localparam int unsigned JMP_REG_HI   = W - 1 - JMP_REG_OFS;
   localparam int unsigned JMP_ASEL_BIT = JMP_REG_HI - REG_SEL_WIDTH;
   localparam int unsigned P_RSIN_HI    = W - 1 - REG_SEL_WIDTH;

   ctrl_seq_state_e state_q, state_d;
   opcode_e         opcode;
   logic            advance, jmp_taken, tmo_clear, tmo_enable, tmo_expired;

   logic [1:0]               mem_ctrl_op_q, mem_ctrl_op_d;
   logic [2:0]               addr_reg_op_q, addr_reg_op_d;
   logic                     addr_sel_q, addr_sel_d;
   logic [ALU_OP_WIDTH-1:0]  alu_op_q, alu_op_d;
   logic                     reg_op_q, reg_op_d;
   logic [REG_SEL_WIDTH-1:0] reg_sel_in_q, reg_sel_in_d;
   logic [REG_SEL_WIDTH-1:0] reg_sel_1_q, reg_sel_1_d;
   logic [REG_SEL_WIDTH-1:0] reg_sel_2_q, reg_sel_2_d;
   logic [1:0]               mux_sel_q, mux_sel_d;
   logic                     halted_q, halted_d;
   logic                     fault_q, fault_d;
   logic                     jmp_asel_q, jmp_asel_d;

`ifdef CTRL_SINGLE_STEP_EN
   assign advance = step;
`else
   assign advance = 1'b1;
`endif

   assign opcode    = opcode_e'(bus_data_in[OPC_LSB +: OPCODE_W]);
   assign jmp_taken = (!bus_data_in[MOD_BIT] && !bus_data_in[JMP_ZM_BIT]) ||
                      (bus_data_in[MOD_BIT] && flag_carry) ||
                      (bus_data_in[JMP_ZM_BIT] && flag_zero);

   // Counter restarts whenever a new wait state is entered
   assign tmo_enable = is_wait_state(state_q);
   assign tmo_clear  = is_wait_state(state_d) && (state_d != state_q);

   ctrl_seq_timeout #(.LIMIT(MEM_TIMEOUT)) u_timeout (
      .clock     (clock),
      .reset     (reset),
      .clear     (tmo_clear),
      .enable    (tmo_enable),
      .expired_c (tmo_expired)
   );

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state_q <= ST_FETCH;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_FETCH:  if (advance) state_d = ST_DECODE;
         ST_DECODE: begin
            if (mem_op_done) begin
               case (opcode)
                  OP_NOP:  state_d = bus_data_in[MOD_BIT] ? ST_HALT : ST_INC_PC;
                  OP_ALU:  state_d = ST_ALU_OP;
                  OP_LDX:  state_d = bus_data_in[MOD_BIT] ? ST_LDX_READ : ST_LDX_WRITE;
                  default: state_d = jmp_taken ? ST_JMP_PARAM : ST_INC_PC;
               endcase
            end else if (tmo_expired) begin
               state_d = ST_FAULT;
            end
         end
         ST_ALU_OP, ST_LDX_READ, ST_LDX_WRITE, ST_JMP_PARAM: begin
            if (mem_op_done)      state_d = ST_INC_PC;
            else if (tmo_expired) state_d = ST_FAULT;
         end
         ST_INC_PC: state_d = ST_FETCH;
         ST_HALT:   state_d = ST_HALT;
         ST_FAULT:  state_d = ST_FAULT;
         default:   state_d = ST_FETCH;
      endcase
   end

   // Next registered output values; waiting states re-load their own outputs
   always_comb begin
      mem_ctrl_op_d = MEM_NOP;
      addr_reg_op_d = AR_NOP;
      addr_sel_d    = ADDR_PC;
      alu_op_d      = ALU_OP_WIDTH'(ALU_THR);
      reg_op_d      = REG_NOP;
      reg_sel_in_d  = '0;
      reg_sel_1_d   = '0;
      reg_sel_2_d   = '0;
      mux_sel_d     = MUX_ALU;
      jmp_asel_d    = jmp_asel_q;
      case (state_q)
         ST_FETCH: begin
            if (advance) begin
               mem_ctrl_op_d = MEM_READ;
               mux_sel_d     = MUX_MEM;
            end
         end
         ST_DECODE: begin
            if (mem_op_done) begin
               case (opcode)
                  OP_ALU: begin
                     alu_op_d      = bus_data_in[MOD_BIT -: ALU_OP_WIDTH];
                     reg_sel_1_d   = bus_data_in[ALU_RS1_HI -: REG_SEL_WIDTH];
                     addr_reg_op_d = AR_INC;
                  end
                  OP_LDX: begin
                     addr_sel_d = ADDR_MAR;
                     if (bus_data_in[MOD_BIT]) begin
                        mem_ctrl_op_d = MEM_READ;
                        mux_sel_d     = MUX_MEM;
                        reg_sel_in_d  = bus_data_in[LDX_REG_HI -: REG_SEL_WIDTH];
                     end else begin
                        mem_ctrl_op_d = MEM_WRITE;
                        reg_sel_1_d   = bus_data_in[LDX_REG_HI -: REG_SEL_WIDTH];
                     end
                  end
                  OP_JMP: begin
                     jmp_asel_d = bus_data_in[JMP_ASEL_BIT];
                     if (jmp_taken) begin
                        addr_reg_op_d = AR_INC;
                        reg_sel_1_d   = bus_data_in[JMP_REG_HI -: REG_SEL_WIDTH];
                     end
                  end
                  default: ;
               endcase
            end else if (!tmo_expired) begin
               mem_ctrl_op_d = MEM_READ;
               mux_sel_d     = MUX_MEM;
            end
         end
         ST_ALU_OP: begin
            if (mem_op_done) begin
               alu_op_d    = alu_op_q;
               reg_sel_1_d = reg_sel_1_q;
               reg_sel_2_d = bus_data_in[W-1 -: REG_SEL_WIDTH];
               reg_sel_in_d = bus_data_in[P_RSIN_HI -: REG_SEL_WIDTH];
               reg_op_d    = REG_WRITE;
            end else if (!tmo_expired) begin
               alu_op_d      = alu_op_q;
               reg_sel_1_d   = reg_sel_1_q;
               mem_ctrl_op_d = MEM_READ;
            end
         end
         ST_LDX_READ: begin
            if (mem_op_done || !tmo_expired) begin
               addr_sel_d   = addr_sel_q;
               mux_sel_d    = mux_sel_q;
               reg_sel_in_d = reg_sel_in_q;
            end
            if (mem_op_done)       reg_op_d      = REG_WRITE;
            else if (!tmo_expired) mem_ctrl_op_d = mem_ctrl_op_q;
         end
         ST_LDX_WRITE: begin
            if (!mem_op_done && !tmo_expired) begin
               mem_ctrl_op_d = mem_ctrl_op_q;
               addr_sel_d    = addr_sel_q;
               reg_sel_1_d   = reg_sel_1_q;
            end
         end
         ST_JMP_PARAM: begin
            if (mem_op_done) begin
               addr_sel_d    = jmp_asel_q;
               addr_reg_op_d = bus_data_in[W-1 -: AR_OP_W];
               reg_sel_1_d   = reg_sel_1_q;
            end else if (!tmo_expired) begin
               mem_ctrl_op_d = MEM_READ;
               reg_sel_1_d   = reg_sel_1_q;
            end
         end
         ST_INC_PC: addr_reg_op_d = AR_INC;
         default: ;
      endcase
      halted_d = (state_d == ST_HALT);
      fault_d  = (state_d == ST_FAULT);
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         mem_ctrl_op_q <= MEM_NOP;
         addr_reg_op_q <= AR_NOP;
         addr_sel_q    <= ADDR_PC;
         alu_op_q      <= ALU_OP_WIDTH'(ALU_THR);
         reg_op_q      <= REG_NOP;
         reg_sel_in_q  <= '0;
         reg_sel_1_q   <= '0;
         reg_sel_2_q   <= '0;
         mux_sel_q     <= MUX_ALU;
         halted_q      <= 1'b0;
         fault_q       <= 1'b0;
         jmp_asel_q    <= 1'b0;
      end else begin
         mem_ctrl_op_q <= mem_ctrl_op_d;
         addr_reg_op_q <= addr_reg_op_d;
         addr_sel_q    <= addr_sel_d;
         alu_op_q      <= alu_op_d;
         reg_op_q      <= reg_op_d;
         reg_sel_in_q  <= reg_sel_in_d;
         reg_sel_1_q   <= reg_sel_1_d;
         reg_sel_2_q   <= reg_sel_2_d;
         mux_sel_q     <= mux_sel_d;
         halted_q      <= halted_d;
         fault_q       <= fault_d;
         jmp_asel_q    <= jmp_asel_d;
      end
   end

   assign mem_ctrl_op = mem_ctrl_op_q;
   assign addr_reg_op = addr_reg_op_q;
   assign addr_sel    = addr_sel_q;
   assign alu_op      = alu_op_q;
   assign reg_op      = reg_op_q;
   assign reg_sel_in  = reg_sel_in_q;
   assign reg_sel_1   = reg_sel_1_q;
   assign reg_sel_2   = reg_sel_2_q;
   assign mux_sel     = mux_sel_q;
   assign halted      = halted_q;
   assign fault       = fault_q;

endmodule

// File: tb/tb_ctrl_seq.sv
// Directed bench for ctrl_seq: each instruction class, halt, timeout and reset.
module tb_ctrl_seq;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       step  = 1'b1;
   logic [7:0] bus_data_in = 8'h00;
   logic       mem_op_done = 1'b0;
   logic       flag_carry  = 1'b0;
   logic       flag_zero   = 1'b0;
   logic [1:0] mem_ctrl_op;
   logic [2:0] addr_reg_op;
   logic       addr_sel;
   logic [3:0] alu_op;
   logic       reg_op;
   logic [1:0] reg_sel_in, reg_sel_1, reg_sel_2;
   logic [1:0] mux_sel;
   logic       halted, fault;

   int n_assert = 0;
   int n_fail   = 0;

   ctrl_seq #(
      .DATA_BUS_WIDTH(8), .REG_SEL_WIDTH(2), .ALU_OP_WIDTH(4), .MEM_TIMEOUT(15)
   ) dut (
      .clock       (clock),
      .reset       (reset),
`ifdef CTRL_SINGLE_STEP_EN
      .step        (step),
`endif
      .bus_data_in (bus_data_in),
      .mem_op_done (mem_op_done),
      .flag_carry  (flag_carry),
      .flag_zero   (flag_zero),
      .mem_ctrl_op (mem_ctrl_op),
      .addr_reg_op (addr_reg_op),
      .addr_sel    (addr_sel),
      .alu_op      (alu_op),
      .reg_op      (reg_op),
      .reg_sel_in  (reg_sel_in),
      .reg_sel_1   (reg_sel_1),
      .reg_sel_2   (reg_sel_2),
      .mux_sel     (mux_sel),
      .halted      (halted),
      .fault       (fault)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // From ST_INC_PC: expect the PC increment, then a fresh fetch
   task automatic finish_instr(input string tag);
      tick();
      chk({tag, "_inc"}, 32'(addr_reg_op), 1);
      chk({tag, "_inc_regop"}, 32'(reg_op), 0);
      tick();
      chk({tag, "_refetch"}, 32'(mem_ctrl_op), 1);
   endtask

   initial begin
      repeat (2) @(posedge clock);
      #1;
      chk("rst_mem", 32'(mem_ctrl_op), 0);
      chk("rst_arop", 32'(addr_reg_op), 0);
      chk("rst_mux", 32'(mux_sel), 0);
      chk("rst_halted", 32'(halted), 0);
      chk("rst_fault", 32'(fault), 0);
      reset = 1'b1;

      tick();
      chk("fetch_mem", 32'(mem_ctrl_op), 1);
      chk("fetch_mux", 32'(mux_sel), 1);
      chk("fetch_asel", 32'(addr_sel), 0);

      // NOP, done after two cycles
      bus_data_in = 8'h00;
      tick();
      chk("nop_wait_mem", 32'(mem_ctrl_op), 1);
      mem_op_done = 1'b1;
      tick();
      chk("nop_done_mem", 32'(mem_ctrl_op), 0);
      chk("nop_done_arop", 32'(addr_reg_op), 0);
      mem_op_done = 1'b0;
      finish_instr("nop");

      // ALU 0x4D then param 0xB0
      bus_data_in = 8'h4D; mem_op_done = 1'b1;
      tick();
      chk("alu_dec_op", 32'(alu_op), 3);
      chk("alu_dec_rs1", 32'(reg_sel_1), 1);
      chk("alu_dec_arop", 32'(addr_reg_op), 1);
      bus_data_in = 8'hB0; mem_op_done = 1'b0;
      tick();
      chk("alu_wait_mem", 32'(mem_ctrl_op), 1);
      chk("alu_wait_arop", 32'(addr_reg_op), 0);
      chk("alu_wait_regop", 32'(reg_op), 0);
      mem_op_done = 1'b1;
      tick();
      chk("alu_wr_regop", 32'(reg_op), 1);
      chk("alu_wr_rs2", 32'(reg_sel_2), 2);
      chk("alu_wr_rsin", 32'(reg_sel_in), 3);
      chk("alu_wr_op", 32'(alu_op), 3);
      chk("alu_wr_mux", 32'(mux_sel), 0);
      chk("alu_wr_mem", 32'(mem_ctrl_op), 0);
      mem_op_done = 1'b0;
      finish_instr("alu");

      // LDX read 0xA8 (reg 1)
      bus_data_in = 8'hA8; mem_op_done = 1'b1;
      tick();
      chk("ldr_asel", 32'(addr_sel), 1);
      chk("ldr_mux", 32'(mux_sel), 1);
      chk("ldr_rsin", 32'(reg_sel_in), 1);
      chk("ldr_mem", 32'(mem_ctrl_op), 1);
      chk("ldr_regop", 32'(reg_op), 0);
      mem_op_done = 1'b0;
      tick();
      chk("ldr_hold_asel", 32'(addr_sel), 1);
      chk("ldr_hold_regop", 32'(reg_op), 0);
      mem_op_done = 1'b1;
      tick();
      chk("ldr_done_regop", 32'(reg_op), 1);
      chk("ldr_done_rsin", 32'(reg_sel_in), 1);
      chk("ldr_done_mux", 32'(mux_sel), 1);
      mem_op_done = 1'b0;
      finish_instr("ldr");

      // LDX write 0x90 (reg 2)
      bus_data_in = 8'h90; mem_op_done = 1'b1;
      tick();
      chk("ldw_mem", 32'(mem_ctrl_op), 2);
      chk("ldw_rs1", 32'(reg_sel_1), 2);
      chk("ldw_asel", 32'(addr_sel), 1);
      chk("ldw_mux", 32'(mux_sel), 0);
      mem_op_done = 1'b0;
      repeat (2) begin
         tick();
         chk("ldw_hold_mem", 32'(mem_ctrl_op), 2);
      end
      mem_op_done = 1'b1;
      tick();
      chk("ldw_done_mem", 32'(mem_ctrl_op), 0);
      chk("ldw_done_regop", 32'(reg_op), 0);
      mem_op_done = 1'b0;
      finish_instr("ldw");

      // JMP 0xE2 taken on carry, param 0x60
      bus_data_in = 8'hE2; flag_carry = 1'b1; mem_op_done = 1'b1;
      tick();
      chk("jmp_dec_arop", 32'(addr_reg_op), 1);
      bus_data_in = 8'h60; mem_op_done = 1'b0;
      tick();
      chk("jmp_wait_mem", 32'(mem_ctrl_op), 1);
      mem_op_done = 1'b1;
      tick();
      chk("jmp_asel", 32'(addr_sel), 1);
      chk("jmp_arop", 32'(addr_reg_op), 3);
      mem_op_done = 1'b0; flag_carry = 1'b0;
      finish_instr("jmp");

      // JMP 0xE2 not taken
      bus_data_in = 8'hE2; mem_op_done = 1'b1;
      tick();
      chk("jnt_arop", 32'(addr_reg_op), 0);
      chk("jnt_asel", 32'(addr_sel), 0);
      mem_op_done = 1'b0;
      finish_instr("jnt");

      // Timeout in ST_DECODE
      bus_data_in = 8'h00;
      repeat (14) tick();
      chk("tmo_pre_fault", 32'(fault), 0);
      tick();
      chk("tmo_fault", 32'(fault), 1);
      chk("tmo_mem", 32'(mem_ctrl_op), 0);
      mem_op_done = 1'b1;
      repeat (3) tick();
      chk("tmo_sticky", 32'(fault), 1);
      chk("tmo_halted", 32'(halted), 0);
      chk("tmo_sticky_mem", 32'(mem_ctrl_op), 0);
      mem_op_done = 1'b0;
      reset = 1'b0;
      #2;
      chk("tmo_rst_fault", 32'(fault), 0);
      @(negedge clock);
      reset = 1'b1;
      tick();
      chk("tmo_rst_fetch", 32'(mem_ctrl_op), 1);

      // Done on the fifteenth wait cycle wins over the timeout
      repeat (14) tick();
      mem_op_done = 1'b1;
      tick();
      chk("tmo_edge_fault", 32'(fault), 0);
      chk("tmo_edge_arop", 32'(addr_reg_op), 0);
      mem_op_done = 1'b0;
      finish_instr("tmo_edge");

      // HALT 0x20
      bus_data_in = 8'h20; mem_op_done = 1'b1;
      tick();
      chk("hlt_halted", 32'(halted), 1);
      chk("hlt_mem", 32'(mem_ctrl_op), 0);
      mem_op_done = 1'b0;
      repeat (3) tick();
      mem_op_done = 1'b1;
      repeat (2) tick();
      chk("hlt_stay", 32'(halted), 1);
      chk("hlt_stay_mem", 32'(mem_ctrl_op), 0);
      chk("hlt_stay_arop", 32'(addr_reg_op), 0);
      chk("hlt_fault", 32'(fault), 0);
      mem_op_done = 1'b0;
      reset = 1'b0;
      #2;
      chk("hlt_rst", 32'(halted), 0);
      @(negedge clock);
      reset = 1'b1;
      tick();
      chk("hlt_rst_fetch", 32'(mem_ctrl_op), 1);

      // Reset while ALU waits for its parameter: no register write escapes
      bus_data_in = 8'h4D; mem_op_done = 1'b1;
      tick();
      bus_data_in = 8'hB0;
      #2;
      reset = 1'b0;
      #2;
      chk("mid_rst_regop", 32'(reg_op), 0);
      chk("mid_rst_alu", 32'(alu_op), 0);
      tick();
      chk("mid_rst_regop_hold", 32'(reg_op), 0);
      @(negedge clock);
      reset = 1'b1; mem_op_done = 1'b0;
      tick();
      chk("mid_rst_fetch", 32'(mem_ctrl_op), 1);
      chk("mid_rst_regop_after", 32'(reg_op), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/ctrl_seq.md
Name: ctrl_seq

Overview:
Parametrised next-generation instruction sequencer for the simple-viii core. Fetches and decodes NOP/HALT, ALU, LDX and JMP instructions, sequences the memory controller, address registers, register file, ALU and bus mux, and drives all of their control signals as registered outputs. Compared with the first-generation controller it:
- generalises operand field widths;
- adds a HALT instruction;
- uses mask-based jump conditions;
- adds a memory-handshake timeout with a sticky fault state.

Parameters:
DATA_BUS_WIDTH, 8, instruction/data byte width; must be >= 2+ALU_OP_WIDTH+REG_SEL_WIDTH
REG_SEL_WIDTH, 2, register-select width (2**REG_SEL_WIDTH registers)
ALU_OP_WIDTH, 4, ALU opcode width
MEM_TIMEOUT, 15, maximum cycles waiting for mem_op_done; 0 disables the timeout

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-low reset
bus_data_in  in  DATA_BUS_WIDTH  memory read data (opcode/param byte)
mem_op_done  in  1  memory controller completion strobe
flag_carry  in  1  ALU carry flag
flag_zero  in  1  ALU zero flag
mem_ctrl_op  out  2  MEM_NOP=0, MEM_READ=1, MEM_WRITE=2
addr_reg_op  out  3  AR_NOP=0, INC=1, others passed through from the JMP param byte
addr_sel  out  1  PC=0, MAR=1
alu_op  out  ALU_OP_WIDTH  ALU operation; THR=0
reg_op  out  1  REG_NOP=0, REG_WRITE=1
reg_sel_in, reg_sel_1, reg_sel_2  out  REG_SEL_WIDTH each  register selects
mux_sel  out  2  MUX_ALU=0, MUX_MEM=1
halted  out  1  high while in ST_HALT
fault  out  1  high while in ST_FAULT

Behaviour:
Output timing:
- All outputs are registered: next values are computed combinationally from state and inputs and loaded on the rising clock.
- Values not explicitly driven in a state take their defaults: MEM_NOP, AR_NOP, PC, THR, REG_NOP, reg selects 0, MUX_ALU.

Reset:
- reset low forces state ST_FETCH, all outputs to their defaults, halted=0, fault=0, and the timeout counter to 0.
- Reset mid-operation abandons the instruction with no partial register write.

Instruction byte 0 fields (W=DATA_BUS_WIDTH):
- [W-1:W-2] opcode: NOP=0, ALU=1, LDX=2, JMP=3.

States and transitions:
- ST_FETCH: MEM_READ, PC, MUX_MEM. Next ST_DECODE.
- ST_DECODE: holds MEM_READ/PC/MUX_MEM until mem_op_done, then decodes by opcode:
  - NOP: bit W-3=1 -> ST_HALT; otherwise -> ST_INC_PC.
  - ALU: alu_op=[W-3 -: ALU_OP_WIDTH], reg_sel_1=the next REG_SEL_WIDTH bits; INC PC -> ST_ALU_OP.
  - LDX: bit W-3 is direction, reg=next REG_SEL_WIDTH bits.
    - dir=1: MEM_READ, MAR, MUX_MEM, reg_sel_in=reg -> ST_LDX_READ.
    - dir=0: MEM_WRITE, MAR, MUX_ALU, THR, reg_sel_1=reg -> ST_LDX_WRITE.
  - JMP: bit W-3 = carry mask cm, bit W-4 = zero mask zm, then reg_sel_1 (REG_SEL_WIDTH bits), then the addr-select bit (latched internally).
    - taken = (cm==0 && zm==0) || (cm && flag_carry) || (zm && flag_zero).
    - not taken -> ST_INC_PC.
    - taken -> INC PC, -> ST_JMP_PARAM.
- ST_ALU_OP: holds alu_op and reg_sel_1; MEM_READ PC until mem_op_done. Then:
  - reg_sel_2=byte1[W-1 -: REG_SEL_WIDTH], reg_sel_in=the next field;
  - MEM_NOP, MUX_ALU, REG_WRITE;
  - -> ST_INC_PC.
- ST_LDX_READ: holds its outputs; on mem_op_done, REG_WRITE -> ST_INC_PC.
- ST_LDX_WRITE: holds its outputs; on mem_op_done -> ST_INC_PC.
- ST_JMP_PARAM: MEM_READ PC until mem_op_done. Then addr_sel=latched bit, addr_reg_op=byte1[W-1:W-3] -> ST_INC_PC.
- ST_INC_PC: INC, PC -> ST_FETCH.
- ST_HALT: default outputs, halted=1. Exits only by reset.
- ST_FAULT: default outputs, fault=1. Exits only by reset.
- Illegal state encodings -> ST_FETCH.

Timeout:
- The counter clears on entry to any wait state (ST_DECODE, ST_ALU_OP, ST_LDX_READ, ST_LDX_WRITE, ST_JMP_PARAM) and increments each cycle spent waiting.
- If it reaches MEM_TIMEOUT with mem_op_done low, next state is ST_FAULT.
- mem_op_done in that same cycle wins: it takes precedence over the timeout.
- mem_op_done outside a wait state is ignored.

Optional Feature:
CTRL_SINGLE_STEP_EN:
- Defined: adds input step (1 bit). ST_FETCH holds all outputs at their defaults and does not advance until step=1, so exactly one instruction executes per step pulse. step is ignored in all other states.
- Undefined: no step port; ST_FETCH always advances.

Decomposition:
- Package ctrl_seq_pkg holds:
  - mem_ctrl_op_e, addr_register_op_e, addr_sel_e, registers_op_e, mux_sel_e, opcode_e;
  - the ctrl_seq_state_e enum;
  - field-offset localparams derived from the widths.
- One sub-module, ctrl_seq_timeout: a wait counter with clear/enable inputs and an expired output.

Test Plan:
- Reset, then NOP byte 0x00 with mem_op_done after 2 cycles -> observe ST_INC_PC (addr_reg_op=INC), then fetch restarts (mem_ctrl_op=MEM_READ).
- ALU 0x4D (alu_op=3, reg_sel_1=1), param 0xB0 -> reg_op=REG_WRITE with reg_sel_2=2, reg_sel_in=3, alu_op=3, mux_sel=MUX_ALU, in that single cycle.
- LDX read 0xA8 (reg 1) -> addr_sel=MAR, MUX_MEM, reg_sel_in=1, REG_WRITE on done. LDX write 0x90 (reg 2) -> MEM_WRITE held until done.
- JMP 0xE2 with flag_carry=1, param 0x60 -> addr_sel=MAR, addr_reg_op=3. Same with flag_carry=0, flag_zero=0 -> straight to INC.
- NOP 0x20 -> halted=1 indefinitely, outputs at defaults. Reset clears halted.
- MEM_TIMEOUT=15, mem_op_done never asserted in ST_DECODE -> fault=1 after 15 wait cycles. mem_op_done on cycle 15 -> no fault.
